font_rom_scheduler: RTL

FONT_ROM_SCHEDULER -- requirements
Module: font_rom_scheduler

---
 rtl/font_rom_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/font_rom_scheduler.sv
// rtl/font_rom_scheduler.sv - text-mode pixel pipeline sharing one font ROM port with a host reader
module font_rom_scheduler #(
    parameter int COLS = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    output logic [11:0] tb_addr,
    input  logic [6:0]  tb_data,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        host_req,
    input  logic [10:0] host_addr,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic        pixel_on,
    output logic        video_on_d
);

    // Pixel-to-output depth: tb_addr, text RAM, rom_addr, font ROM, pixel_on.
    localparam int LATENCY = 5;
    localparam int DLY     = LATENCY - 1;

    typedef enum logic [1:0] {
        H_IDLE,
        H_WAIT,
        H_DATA
    } host_state_e;

    logic [6:0]  col;
    logic [4:0]  text_row;
    logic [11:0] cell_addr;
    logic        unused_pixel_y9;

    assign col             = pixel_x[9:3];
    assign text_row        = pixel_y[8:4];
    assign unused_pixel_y9 = pixel_y[9];

    // Row*80 folds into two shifts and an add; other widths fall back to a multiplier.
    if (COLS == 80) begin : g_mul80
        assign cell_addr = ({7'd0, text_row} << 6) + ({7'd0, text_row} << 4) + {5'd0, col};
    end else begin : g_mul_generic
        assign cell_addr = 12'(int'(text_row) * COLS + int'(col));
    end

    // Index 0 is the tb_addr stage, index DLY-1 feeds the output stage.
    logic [DLY-1:0]       von_q;
    logic [DLY-1:0][2:0]  bsel_q;
    logic [3:0]           frow_s1_q;
    logic [3:0]           frow_s2_q;
    logic [11:0]          tb_addr_q;
    logic                 pixel_on_q;
    logic                 video_on_d_q;

    logic [10:0]          rom_addr_q,    rom_addr_d;
    logic                 host_gnt_q,    host_gnt_d;
    logic                 host_rvalid_q, host_rvalid_d;
    logic [7:0]           host_rdata_q,  host_rdata_d;
    host_state_e          state_q,       state_d;

    // Display owns the ROM port on the edge that registers rom_addr for an active pixel.
    logic disp_slot;
    assign disp_slot = von_q[1];

    // Display pipeline: cell address plus aligned font row, bit select and video_on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_addr_q    <= '0;
            von_q        <= '0;
            bsel_q       <= '0;
            frow_s1_q    <= '0;
            frow_s2_q    <= '0;
            pixel_on_q   <= 1'b0;
            video_on_d_q <= 1'b0;
        end else begin
            tb_addr_q    <= cell_addr;
            von_q        <= {von_q[DLY-2:0], video_on};
            bsel_q       <= {bsel_q[DLY-2:0], pixel_x[2:0]};
            frow_s1_q    <= pixel_y[3:0];
            frow_s2_q    <= frow_s1_q;
            pixel_on_q   <= von_q[DLY-1] & rom_data[~bsel_q[DLY-1]];
            video_on_d_q <= von_q[DLY-1];
        end
    end

    // ROM port arbitration and host read state machine.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        host_gnt_d    = 1'b0;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        if (disp_slot) begin
            rom_addr_d = {tb_data, frow_s2_q};
        end
        case (state_q)
            H_IDLE: begin
                if (host_req && !disp_slot) begin
                    rom_addr_d = host_addr;
                    host_gnt_d = 1'b1;
                    state_d    = H_WAIT;
                end
            end
            H_WAIT: begin
                state_d = H_DATA;
            end
            H_DATA: begin
                host_rdata_d  = rom_data;
                host_rvalid_d = 1'b1;
                state_d       = H_IDLE;
            end
            default: begin
                state_d = H_IDLE;
            end
        endcase
    end

    // Arbitration and host registers; reset abandons any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= H_IDLE;
            rom_addr_q    <= '0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            host_gnt_q    <= host_gnt_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign tb_addr     = tb_addr_q;
    assign rom_addr    = rom_addr_q;
    assign host_gnt    = host_gnt_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign pixel_on    = pixel_on_q;
    assign video_on_d  = video_on_d_q;

endmodule
